// File: rtl/motor_math_pkg.sv
`default_nettype none
// ============================================================================
// Module  : motor_math_pkg
// Brief   : Shared constants and tag type for shared-divider schedulers.
// Revision: 1.0 - initial release
// ============================================================================
package motor_math_pkg;

    localparam int USMOD_W       = 16;
    localparam int USMOD_LATENCY = 10;
    // Wide enough for up to 8 requesters so every scheduler can share the type.
    localparam int TAG_ID_W      = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                zero;
        logic [USMOD_W-1:0]  a;
    } usmod_tag_t;

    localparam int USMOD_TAG_W = $bits(usmod_tag_t);

endpackage
`default_nettype wire

// File: rtl/usmod_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : usmod_sched_if
// Brief   : Requester, divider and response signals of the modulo scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface usmod_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import motor_math_pkg::*;

    logic [NREQ-1:0]         req;
    logic [USMOD_W*NREQ-1:0] req_a;
    logic [USMOD_W*NREQ-1:0] req_b;
    logic [NREQ-1:0]         gnt;
    logic [USMOD_W-1:0]      div_a;
    logic [USMOD_W-1:0]      div_b;
    logic                    div_start;
    logic [USMOD_W-1:0]      div_q;
    logic                    rsp_valid;
    logic [IDW-1:0]          rsp_id;
    logic [USMOD_W-1:0]      rsp_q;
    logic                    rsp_err;
    logic                    busy;

    modport slave (
        input  req, req_a, req_b, div_q,
        output gnt, div_a, div_b, div_start,
        output rsp_valid, rsp_id, rsp_q, rsp_err, busy
    );

    modport master (
        output req, req_a, req_b, div_q,
        input  gnt, div_a, div_b, div_start,
        input  rsp_valid, rsp_id, rsp_q, rsp_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/usmod_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : usmod_tag_pipe
// Brief   : DEPTH-stage delay line of d1 registers with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
module usmod_tag_pipe #(
    parameter int WIDTH     = 21,
    parameter int DEPTH     = 10,
    parameter int VALID_BIT = WIDTH - 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q,
    output logic      [DEPTH-1:0] o_valid
);

    // Slice 0 is the input; slice s+1 is the output of stage s.
    logic [(DEPTH+1)*WIDTH-1:0] w_chain;

    assign w_chain[WIDTH-1:0] = i_d;

    generate
        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_chain[s*WIDTH +: WIDTH];
                end
            end

            assign w_chain[(s+1)*WIDTH +: WIDTH] = r_q;
            assign o_valid[s]                    = r_q[VALID_BIT];
        end
    endgenerate

    assign o_q = w_chain[DEPTH*WIDTH +: WIDTH];

endmodule
`default_nettype wire

// File: rtl/usmod_sched.sv
`default_nettype none
// ============================================================================
// Module  : usmod_sched
// Brief   : Round-robin scheduler sharing one pipelined modulo unit.
// Revision: 1.0 - initial release
// ============================================================================
module usmod_sched
    import motor_math_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int LATENCY = USMOD_LATENCY
) (
    input  wire logic    c,
    input  wire logic    rst,
    usmod_sched_if.slave bus
);

    localparam int c_TAG_W = USMOD_TAG_W;

    logic [IDW-1:0]     r_ptr;
    logic               w_hit;
    logic [IDW-1:0]     w_idx;
    logic [NREQ-1:0]    w_gnt;
    logic [USMOD_W-1:0] w_op_a;
    logic [USMOD_W-1:0] w_op_b;
    logic [USMOD_W-1:0] r_div_a;
    logic [USMOD_W-1:0] r_div_b;
    usmod_tag_t         w_tag_in;
    usmod_tag_t         w_tag_out;
    logic [c_TAG_W-1:0] w_tag_bits;
    logic [LATENCY-1:0] w_valid_vec;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [USMOD_W-1:0] r_rsp_q;
    logic               r_rsp_err;

    // First requester at or after the pointer wins; nothing issues while in reset.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!w_hit && bus.req[(int'(r_ptr) + off) % NREQ]) begin
                w_hit = 1'b1;
                w_idx = IDW'((int'(r_ptr) + off) % NREQ);
            end
        end
        if (rst) begin
            w_hit = 1'b0;
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_hit) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    assign w_op_a = bus.req_a[int'(w_idx)*USMOD_W +: USMOD_W];
    assign w_op_b = bus.req_b[int'(w_idx)*USMOD_W +: USMOD_W];

    always_ff @(posedge c) begin
        if (rst) begin
            r_ptr   <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
        end else if (w_hit) begin
            r_ptr   <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + IDW'(1);
            r_div_a <= w_op_a;
            r_div_b <= w_op_b;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.div_start = w_hit;
    assign bus.div_a     = w_hit ? w_op_a : r_div_a;
    assign bus.div_b     = w_hit ? w_op_b : r_div_b;

    always_comb begin
        w_tag_in = '0;
        if (w_hit) begin
            w_tag_in.valid = 1'b1;
            w_tag_in.id    = TAG_ID_W'(w_idx);
            w_tag_in.zero  = (w_op_b == '0);
            w_tag_in.a     = w_op_a;
        end
    end

    usmod_tag_pipe #(
        .WIDTH     (c_TAG_W),
        .DEPTH     (LATENCY),
        .VALID_BIT (c_TAG_W - 1)
    ) u_tag_pipe (
        .clk     (c),
        .rst     (rst),
        .i_d     (w_tag_in),
        .o_q     (w_tag_bits),
        .o_valid (w_valid_vec)
    );

    assign w_tag_out = w_tag_bits;

    generate
        if (IDW < TAG_ID_W) begin : g_id_trim
            logic w_unused_id;
            assign w_unused_id = ^w_tag_out.id[TAG_ID_W-1:IDW];
        end
    endgenerate

    // A zero divisor returns the numerator and never looks at div_q.
    always_ff @(posedge c) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_q     <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_tag_out.valid;
            if (w_tag_out.valid) begin
                r_rsp_id  <= IDW'(w_tag_out.id);
                r_rsp_q   <= w_tag_out.zero ? w_tag_out.a : bus.div_q;
                r_rsp_err <= w_tag_out.zero;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_q     = r_rsp_q;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = (|w_valid_vec) | w_hit;

endmodule
`default_nettype wire

// File: tb/tb_usmod_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_usmod_sched
// Brief   : Directed plus random checks of usmod_sched against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_usmod_sched;
    import motor_math_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = USMOD_LATENCY;

    typedef struct {
        int          due;
        int          id;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic c   = 1'b0;
    logic rst = 1'b1;

    always #5 c = ~c;

    usmod_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    usmod_sched #(.NREQ(NREQ), .IDW(IDW), .LATENCY(LAT)) dut (
        .c   (c),
        .rst (rst),
        .bus (bus)
    );

    // Divider stand-in: fixed latency, garbage on bubbles and on b == 0.
    logic [15:0] dpipe [1:LAT];
    always @(posedge c) begin
        dpipe[1] <= bus.div_start ? ((bus.div_b == 16'h0) ? 16'hDEAD : bus.div_a % bus.div_b)
                                  : 16'($urandom);
        for (int s = 2; s <= LAT; s++) dpipe[s] <= dpipe[s-1];
    end
    assign bus.div_q = dpipe[LAT];

    int          total;
    int          bad;
    int          cyc;
    int          mptr;
    bit          refill;
    logic        mreq [NREQ];
    logic [15:0] ma   [NREQ];
    logic [15:0] mb   [NREQ];
    logic [15:0] last_a, last_b;
    int          lr_id;
    logic [15:0] lr_q;
    logic        lr_err;
    exp_t        sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]               = mreq[i];
            bus.req_a[16*i +: 16]    = ma[i];
            bus.req_b[16*i +: 16]    = mb[i];
        end
    endtask

    function automatic int pick();
        for (int o = 0; o < NREQ; o++) begin
            if (mreq[(mptr + o) % NREQ]) return (mptr + o) % NREQ;
        end
        return -1;
    endfunction

    task automatic step();
        int              g;
        logic [NREQ-1:0] eg;
        @(negedge c);
        g  = rst ? -1 : pick();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("div_start", 32'(bus.div_start), (g >= 0) ? 1 : 0);
        if (g >= 0) begin
            last_a = ma[g];
            last_b = mb[g];
        end
        chk("div_a", 32'(bus.div_a), 32'(last_a));
        chk("div_b", 32'(bus.div_b), 32'(last_b));
        chk("busy", 32'(bus.busy), (sb.size() > 0 || g >= 0) ? 1 : 0);
        @(posedge c);
        cyc++;
        if (rst) begin
            sb.delete();
            mptr   = 0;
            last_a = '0;
            last_b = '0;
            lr_id  = 0;
            lr_q   = '0;
            lr_err = 1'b0;
        end else if (g >= 0) begin
            exp_t e;
            e.due = cyc + LAT;
            e.id  = g;
            e.a   = ma[g];
            e.b   = mb[g];
            sb.push_back(e);
            mptr = (g + 1) % NREQ;
            if (!refill) mreq[g] = 1'b0;
        end
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e = sb.pop_front();
            lr_id  = e.id;
            lr_err = (e.b == 16'h0);
            lr_q   = lr_err ? e.a : e.a % e.b;
            chk("rsp_valid", 32'(bus.rsp_valid), 1);
        end else begin
            chk("rsp_valid", 32'(bus.rsp_valid), 0);
        end
        chk("rsp_id", 32'(bus.rsp_id), 32'(lr_id));
        chk("rsp_q", 32'(bus.rsp_q), 32'(lr_q));
        chk("rsp_err", 32'(bus.rsp_err), 32'(lr_err));
        drive();
    endtask

    task automatic post(input int i, input logic [15:0] a, input logic [15:0] b);
        mreq[i] = 1'b1;
        ma[i]   = a;
        mb[i]   = b;
        drive();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        mptr   = 0;
        refill = 1'b0;
        last_a = '0;
        last_b = '0;
        lr_id  = 0;
        lr_q   = '0;
        lr_err = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            mreq[i] = 1'b0;
            ma[i]   = '0;
            mb[i]   = '0;
        end
        drive();
        rst = 1'b1;
        repeat (2) @(posedge c);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_div_start", 32'(bus.div_start), 0);
        chk("rst_div_a", 32'(bus.div_a), 0);
        chk("rst_div_b", 32'(bus.div_b), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_rsp_q", 32'(bus.rsp_q), 0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;

        // Single op: 100 mod 7
        post(1, 16'd100, 16'd7);
        step();
        repeat (12) step();

        // Divide by zero returns the numerator with err
        post(2, 16'h1234, 16'h0000);
        step();
        repeat (12) step();

        // Full contention for 12 cycles
        refill = 1'b1;
        for (int i = 0; i < NREQ; i++) post(i, 16'(1000 + i), 16'd9);
        repeat (12) step();
        refill = 1'b0;
        for (int i = 0; i < NREQ; i++) mreq[i] = 1'b0;
        drive();
        repeat (12) step();

        // Back-to-back issues with one bubble
        post(0, 16'd55, 16'd6);
        step();
        post(1, 16'd77, 16'd10);
        step();
        step();
        post(2, 16'd91, 16'd13);
        step();
        repeat (12) step();

        // Boundary operands
        post(3, 16'hFFFF, 16'hFFFF);
        step();
        post(3, 16'd5, 16'hFFFF);
        step();
        post(3, 16'hFFFF, 16'd1);
        step();
        repeat (12) step();

        // Reset while three ops are in flight
        post(0, 16'($urandom), 16'($urandom));
        post(1, 16'($urandom), 16'($urandom));
        post(2, 16'($urandom), 16'($urandom));
        repeat (3) step();
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) step();
        post(1, 16'd40, 16'd3);
        post(3, 16'd41, 16'd4);
        repeat (2) step();
        repeat (12) step();

        // Random traffic obeying the hold-until-granted handshake
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!mreq[i] && $urandom_range(1, 0) == 1) begin
                    mreq[i] = 1'b1;
                    ma[i]   = 16'($urandom);
                    case ($urandom_range(7, 0))
                        0:       mb[i] = 16'h0000;
                        1:       mb[i] = 16'hFFFF;
                        2:       mb[i] = 16'h0001;
                        default: mb[i] = 16'($urandom_range(300, 0));
                    endcase
                end
            end
            drive();
            rst = ($urandom_range(99, 0) == 0);
            step();
            rst = 1'b0;
        end
        repeat (16) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usmod_sched.md
Name: usmod_sched

Overview:
- Round-robin scheduler that shares one pipelined 16-bit unsigned modulo unit (op_usmod) among NREQ requesters, e.g. the per-channel commutation and phase-wrap logic in the motor controller.
- Accepts one operation per cycle and pushes it into the divider.
- Carries a tag (requester id, valid, divide-by-zero flag) alongside the operation through a delay line matched to the divider latency.
- Broadcasts each result with its tag, in issue order.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id (clog2(NREQ), minimum 1).
- LATENCY, 10, cycles from div_start to a valid div_q; must equal the divider's fixed latency.

Ports:
- c  input  1  clock
- rst  input  1  synchronous active-high reset
- req  input  NREQ  per-requester request; held with its operands until granted
- req_a  input  16*NREQ  numerators, requester i at bits [16i+15:16i]
- req_b  input  16*NREQ  denominators, same packing
- gnt  output  NREQ  one-hot grant, same cycle as issue
- div_a  output  16  numerator to op_usmod
- div_b  output  16  denominator to op_usmod
- div_start  output  1  issue strobe to op_usmod
- div_q  input  16  remainder from op_usmod
- rsp_valid  output  1  result strobe, one cycle
- rsp_id  output  IDW  requester that owns the result
- rsp_q  output  16  remainder (a mod b)
- rsp_err  output  1  set when b was 0
- busy  output  1  any operation in flight

Behaviour:
- Reset: gnt=0, div_start=0, div_a=div_b=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_err=0, busy=0, round-robin pointer=0, every tag slot invalid.
- Arbitration is combinational over req. Search starts at pointer, wraps modulo NREQ; at most one grant per cycle.
- On a grant to requester i:
  - gnt[i]=1, div_start=1, div_a/div_b = operands of i in the same cycle.
  - Pointer becomes (i+1) mod NREQ on the next edge.
- With no request: pointer holds, div_start=0, div_a/div_b hold their last values.
- Requester handshake: sample gnt at the edge; the requester may change its operands or drop req only after the edge where gnt was seen high. Requests are never queued internally.
- Tag pipe:
  - LATENCY-deep shift register of {valid, id, zero, a}.
  - Entry written when div_start=1; a bubble (valid=0) written otherwise.
  - Shifts every cycle.
- Response at slot LATENCY (an op issued at edge k responds during cycle k+LATENCY):
  - rsp_valid = tag.valid; rsp_id = tag.id.
  - If tag.zero: rsp_q = tag.a, rsp_err = 1. The divider output is ignored for that op, so b=0 never propagates undefined data.
  - Else: rsp_q = div_q, rsp_err = 0.
- rsp_* are registered; when rsp_valid=0, rsp_id/rsp_q/rsp_err hold their last values.
- Throughput: one issue per cycle sustained. Responses come back strictly in issue order with no gaps beyond the issue gaps. No backpressure on responses; consumers must accept every strobe.
- busy = OR of all tag valid bits, plus div_start.
- Simultaneous events:
  - Issue and response in the same cycle are independent.
  - All NREQ requests held continuously: grants rotate 0,1,..,NREQ-1,0 and each requester gets exactly one grant in every NREQ cycles.
- Reset mid-operation: all tags clear immediately. In-flight divider results are discarded and no rsp_valid fires for them. Pointer returns to 0.
- Width rules: a, b, q are 16-bit unsigned; no sign handling. req_a and req_b index by id.

Decomposition:
- Shared package motor_math_pkg:
  - USMOD_W=16, USMOD_LATENCY=10.
  - Tag struct {valid, id, zero, a}, reused by later shared-divider schedulers.
- One sub-module, usmod_tag_pipe: a parameterized-width, LATENCY-deep shift register with synchronous clear, built from d1 stages.
- Arbiter stays inline.

Test Plan:
- Single op: req[1] with a=100, b=7 -> gnt=0010 in that cycle; 10 cycles later rsp_valid=1, rsp_id=1, rsp_q=2, rsp_err=0.
- Divide by zero: req[2] with a=0x1234, b=0 -> response after 10 cycles has rsp_id=2, rsp_q=0x1234, rsp_err=1.
- Full contention: all four req held for 12 cycles, operands a=1000+i, b=9 -> grants rotate 0,1,2,3 repeatedly; 12 contiguous responses with ids in grant order and q=(1000+i) mod 9.
- Back-to-back plus bubble: issue at cycles 0, 1, 3 -> rsp_valid high at cycles 10, 11, 13 and low at 12.
- Reset mid-flight: issue 3 ops, assert rst for one cycle 4 cycles later -> no rsp_valid for 20 cycles after reset; next grant goes to the lowest active req (pointer=0).
- Boundaries: a=0xFFFF, b=0xFFFF gives q=0; a=5, b=0xFFFF gives q=5; a=0xFFFF, b=1 gives q=0 -> all with rsp_err=0.
